fetch_queue_stage: RTL and testbench

Parametrised successor to the single-entry fetch stage. Generates sequential PCs, issues pipelined fetch requests to the iTLB/iCache front (req/ready, in-order responses, up to MAX_OUTSTANDING in flight) and buffers results in a DEPTH-entry instruction queue that decouples fetch from decode. Redirects (exception, jump) flush the queue and squash in-flight responses via an epoch tag. A faulting fetch halts the stage until a redirect.

---
 rtl/fetch_queue_stage_pkg.sv | 20 ++
 rtl/fetch_queue_stage_fifo.sv | 66 ++++++
 rtl/fetch_queue_stage.sv | 152 +++++++++++++++
 tb/tb_fetch_queue_stage.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_stage_pkg.sv
// Shared types and constants for the fetch queue stage: word size, reset/exception
// vectors, the queued fetch entry and the RUN/HALT state encoding.
package fetch_queue_stage_pkg;

  localparam int               FQ_WORD_SIZE    = 32;
  localparam logic [31:0]      FQ_PC_INITIAL   = 32'h0000_1000;
  localparam logic [31:0]      FQ_PC_EXCEPTION = 32'h0000_2000;

  typedef struct packed {
    logic [FQ_WORD_SIZE-1:0] pc;
    logic [FQ_WORD_SIZE-1:0] instr;
    logic                    exc;
  } fetch_entry_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_queue_stage_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries with flush, push, pop and occupancy count.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module fetch_fifo
  import fetch_queue_stage_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != CNT_W'(DEPTH)) || do_pop);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array has no reset; count_q alone says which slots hold data.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_queue_stage.sv
// Pipelined fetch stage: sequential PC generation, credit-limited requests to the
// iTLB/iCache front, epoch-tagged squash on redirect, and a decoupling instruction queue.
module fetch_queue_stage
  import fetch_queue_stage_pkg::*;
#(
  parameter int                   WORD_SIZE       = FQ_WORD_SIZE,
  parameter int                   DEPTH           = 4,
  parameter int                   MAX_OUTSTANDING = 2,
  parameter logic [WORD_SIZE-1:0] PC_INITIAL      = FQ_PC_INITIAL,
  parameter logic [WORD_SIZE-1:0] PC_EXCEPTION    = FQ_PC_EXCEPTION
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 exception_in,
  input  logic                 jump_taken,
  input  logic [WORD_SIZE-1:0] nextpc,
  output logic                 fetch_req,
  output logic [WORD_SIZE-1:0] fetch_req_addr,
  output logic                 fetch_req_epoch,
  input  logic                 fetch_ready,
  input  logic                 fetch_res,
  input  logic                 fetch_res_epoch,
  input  logic [WORD_SIZE-1:0] fetch_res_data,
  input  logic                 fetch_res_exc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] pc_out,
  output logic [WORD_SIZE-1:0] instruction_out,
  output logic                 exception_out,
  output logic                 halted
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if (WORD_SIZE != FQ_WORD_SIZE) begin : g_bad_word_size
    $error("fetch_queue_stage: WORD_SIZE must equal the package entry width");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fetch_queue_stage: DEPTH must be a power of two, at least 2");
  end
  if ((MAX_OUTSTANDING < 1) || (MAX_OUTSTANDING > DEPTH)) begin : g_bad_max_out
    $error("fetch_queue_stage: MAX_OUTSTANDING must be in 1..DEPTH");
  end

  logic [WORD_SIZE-1:0] pc_q, pc_d;
  logic [WORD_SIZE-1:0] resp_pc_q, resp_pc_d;
  logic                 epoch_q, epoch_d;
  logic [CNT_W-1:0]     outstanding_q, outstanding_d;
  logic [CNT_W-1:0]     stale_q, stale_d;
  fetch_state_e         state_q, state_d;

  logic                 redirect;
  logic [WORD_SIZE-1:0] redirect_pc;
  logic [CNT_W:0]       in_use;
  logic                 handshake;
  logic                 res_accept;
  logic                 pop;
  logic [CNT_W-1:0]     fifo_count;
  fetch_entry_t         fifo_head;
  fetch_entry_t         push_entry;

  assign redirect    = exception_in | jump_taken;
  assign redirect_pc = exception_in ? PC_EXCEPTION : nextpc;

  // Credits: every in-flight request already owns a queue slot, so the queue never overflows.
  assign in_use = {1'b0, outstanding_q} + {1'b0, fifo_count};

  // Gated by reset so the request line is quiet while the stage is held in reset.
  assign fetch_req = rst
                  && (state_q == ST_RUN)
                  && (in_use < (CNT_W+1)'(DEPTH))
                  && (outstanding_q < CNT_W'(MAX_OUTSTANDING))
                  && (stale_q == '0)
                  && !redirect;

  assign handshake = fetch_req && fetch_ready;

  // Responses still owed to a squashed epoch are dropped by count, which also covers
  // the case where two redirects toggle the 1-bit epoch back to the old value.
  assign res_accept = fetch_res
                   && (fetch_res_epoch == epoch_q)
                   && (stale_q == '0)
                   && (state_q == ST_RUN)
                   && !redirect;

  always_comb begin
    pc_d          = pc_q;
    resp_pc_d     = resp_pc_q;
    epoch_d       = epoch_q;
    state_d       = state_q;
    outstanding_d = outstanding_q + CNT_W'(handshake) - CNT_W'(fetch_res);
    stale_d       = stale_q - CNT_W'(fetch_res && (stale_q != '0));
    if (redirect) begin
      pc_d      = redirect_pc;
      resp_pc_d = redirect_pc;
      epoch_d   = ~epoch_q;
      state_d   = ST_RUN;
      stale_d   = outstanding_q - CNT_W'(fetch_res);
    end else begin
      if (handshake) pc_d = pc_q + WORD_SIZE'(4);
      if (res_accept) begin
        resp_pc_d = resp_pc_q + WORD_SIZE'(4);
        if (fetch_res_exc) state_d = ST_HALT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q          <= PC_INITIAL;
      resp_pc_q     <= PC_INITIAL;
      epoch_q       <= 1'b0;
      outstanding_q <= '0;
      stale_q       <= '0;
      state_q       <= ST_RUN;
    end else begin
      pc_q          <= pc_d;
      resp_pc_q     <= resp_pc_d;
      epoch_q       <= epoch_d;
      outstanding_q <= outstanding_d;
      stale_q       <= stale_d;
      state_q       <= state_d;
    end
  end

  assign push_entry = '{pc: resp_pc_q, instr: fetch_res_data, exc: fetch_res_exc};
  assign pop        = out_valid && out_ready;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .flush     (redirect),
    .push      (res_accept),
    .push_data (push_entry),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  // Head fields are masked when empty so unwritten storage never reaches decode.
  assign out_valid       = (fifo_count != '0);
  assign pc_out          = out_valid ? fifo_head.pc    : '0;
  assign instruction_out = out_valid ? fifo_head.instr : '0;
  assign exception_out   = out_valid && fifo_head.exc;
  assign fetch_req_addr  = pc_q;
  assign fetch_req_epoch = epoch_q;
  assign halted          = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Scoreboard bench for fetch_queue_stage: a 1-cycle in-order responder, directed PC
// expectations pushed by the stimulus and a monitor comparing every head pop.
module tb_fetch_queue_stage;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         exception_in = 1'b0;
  logic         jump_taken = 1'b0;
  logic [W-1:0] nextpc = '0;
  logic         fetch_req;
  logic [W-1:0] fetch_req_addr;
  logic         fetch_req_epoch;
  logic         fetch_ready = 1'b0;
  logic         fetch_res = 1'b0;
  logic         fetch_res_epoch = 1'b0;
  logic [W-1:0] fetch_res_data = '0;
  logic         fetch_res_exc = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] pc_out;
  logic [W-1:0] instruction_out;
  logic         exception_out;
  logic         halted;

  fetch_queue_stage dut (
    .clk             (clk),
    .rst             (rst),
    .exception_in    (exception_in),
    .jump_taken      (jump_taken),
    .nextpc          (nextpc),
    .fetch_req       (fetch_req),
    .fetch_req_addr  (fetch_req_addr),
    .fetch_req_epoch (fetch_req_epoch),
    .fetch_ready     (fetch_ready),
    .fetch_res       (fetch_res),
    .fetch_res_epoch (fetch_res_epoch),
    .fetch_res_data  (fetch_res_data),
    .fetch_res_exc   (fetch_res_exc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .pc_out          (pc_out),
    .instruction_out (instruction_out),
    .exception_out   (exception_out),
    .halted          (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] pc;
    logic [W-1:0] instr;
    logic         exc;
  } exp_t;

  typedef struct {
    logic [W-1:0] addr;
    logic         epoch;
  } req_t;

  exp_t         exp_q[$];
  req_t         pend_q[$];
  exp_t         mon_e;
  req_t         rsp_r;
  int           n_cmp = 0;
  int           n_mis = 0;
  int           hs_total = 0;
  int           hs_snap = 0;
  int           last_cycles = 0;
  logic         resp_hold = 1'b0;
  logic [W-1:0] fault_addr = '1;

  function automatic logic [W-1:0] instr_of(input logic [W-1:0] a);
    return a ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic expect_pc(input logic [W-1:0] pc, input logic exc);
    exp_q.push_back('{pc: pc, instr: instr_of(pc), exc: exc});
  endtask

  // Consume until every expected entry has been popped, within a cycle budget.
  task automatic drain(input string name);
    int cyc;
    cyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
      out_ready = 1'b1;
      cyc++;
    end
    out_ready   = 1'b0;
    last_cycles = cyc;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_mis++;
      $display("FAIL %s_timeout: %0d entries still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic redirect(input logic exc, input logic jmp, input logic [W-1:0] tgt,
                          input int n);
    @(negedge clk);
    exception_in = exc;
    jump_taken   = jmp;
    nextpc       = tgt;
    repeat (n) @(negedge clk);
    exception_in = 1'b0;
    jump_taken   = 1'b0;
  endtask

  // Front-end model: in-order, 1-cycle response unless held.
  always begin
    @(negedge clk);
    fetch_res       = 1'b0;
    fetch_res_epoch = 1'b0;
    fetch_res_data  = '0;
    fetch_res_exc   = 1'b0;
    if (!rst) begin
      pend_q.delete();
    end else if (!resp_hold && pend_q.size() > 0) begin
      rsp_r           = pend_q.pop_front();
      fetch_res       = 1'b1;
      fetch_res_epoch = rsp_r.epoch;
      fetch_res_data  = instr_of(rsp_r.addr);
      fetch_res_exc   = (rsp_r.addr == fault_addr);
    end
    #1;
    if (fetch_req && fetch_ready) begin
      pend_q.push_back('{addr: fetch_req_addr, epoch: fetch_req_epoch});
      hs_total++;
    end
  end

  // Monitor: every head handshake is compared against the scoreboard.
  always begin
    @(negedge clk);
    #1;
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_mis++;
        $display("FAIL unexpected_pop: got pc %h, required no entry", pc_out);
      end else begin
        mon_e = exp_q.pop_front();
        check("pc_out", pc_out, mon_e.pc);
        check("instruction_out", instruction_out, mon_e.instr);
        check("exception_out", W'(exception_out), W'(mon_e.exc));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_fetch_req", W'(fetch_req), 32'd0);
    check("rst_out_valid", W'(out_valid), 32'd0);
    check("rst_fetch_req_addr", fetch_req_addr, 32'h0000_1000);
    check("rst_epoch", W'(fetch_req_epoch), 32'd0);
    check("rst_halted", W'(halted), 32'd0);
    check("rst_pc_out", pc_out, 32'd0);
    @(negedge clk);
    rst         = 1'b1;
    fetch_ready = 1'b1;

    // 1: sequential streaming with full throughput once filled
    for (int i = 0; i < 8; i++) expect_pc(32'h1000 + 32'(4 * i), 1'b0);
    drain("t1");
    check("t1_stream_cycles_le_12", W'(last_cycles <= 12), 32'd1);

    // 2: decode stalled -> exactly DEPTH requests beyond those consumed
    repeat (10) @(negedge clk);
    #1;
    check("t2_fetch_req_stalled", W'(fetch_req), 32'd0);
    check("t2_out_valid", W'(out_valid), 32'd1);
    check("t2_handshakes", W'(hs_total), 32'd12);
    check("t2_next_addr", fetch_req_addr, 32'h0000_1030);
    for (int i = 0; i < 8; i++) expect_pc(32'h1020 + 32'(4 * i), 1'b0);
    drain("t2");

    // 3: jump with two requests in flight -> late responses squashed
    repeat (10) @(negedge clk);
    resp_hold = 1'b1;
    redirect(1'b0, 1'b1, 32'h0000_1000, 1);
    repeat (4) @(negedge clk);
    #1;
    check("t3_in_flight", W'(pend_q.size()), 32'd2);
    check("t3_first_addr", pend_q[0].addr, 32'h0000_1000);
    check("t3_second_addr", pend_q[1].addr, 32'h0000_1004);
    check("t3_max_outstanding", W'(fetch_req), 32'd0);
    redirect(1'b0, 1'b1, 32'h0000_3000, 1);
    resp_hold = 1'b0;
    for (int i = 0; i < 3; i++) expect_pc(32'h3000 + 32'(4 * i), 1'b0);
    drain("t3");

    // 4: faulting fetch halts the stage until an exception redirect
    fault_addr = 32'h0000_1008;
    redirect(1'b0, 1'b1, 32'h0000_1000, 1);
    expect_pc(32'h1000, 1'b0);
    expect_pc(32'h1004, 1'b0);
    expect_pc(32'h1008, 1'b1);
    drain("t4");
    hs_snap = hs_total;
    repeat (5) @(negedge clk);
    #1;
    check("t4_halted", W'(halted), 32'd1);
    check("t4_no_req", W'(fetch_req), 32'd0);
    check("t4_queue_empty", W'(out_valid), 32'd0);
    check("t4_no_new_handshakes", W'(hs_total), W'(hs_snap));
    fault_addr = '1;
    redirect(1'b1, 1'b0, 32'h0, 1);
    #1;
    check("t4_unhalted", W'(halted), 32'd0);
    expect_pc(32'h2000, 1'b0);
    expect_pc(32'h2004, 1'b0);
    drain("t4b");

    // 5a: exception_in beats jump_taken; held two cycles re-vectors each cycle
    redirect(1'b1, 1'b1, 32'h0000_3000, 2);
    expect_pc(32'h2000, 1'b0);
    expect_pc(32'h2004, 1'b0);
    drain("t5a");

    // 5b: back-to-back redirects with stale responses pending (epoch aliases)
    repeat (10) @(negedge clk);
    resp_hold = 1'b1;
    redirect(1'b0, 1'b1, 32'h0000_4000, 1);
    repeat (3) @(negedge clk);
    #1;
    check("t5_held", W'(pend_q.size()), 32'd2);
    @(negedge clk);
    jump_taken = 1'b1;
    nextpc     = 32'h0000_5000;
    @(negedge clk);
    nextpc     = 32'h0000_6000;
    @(negedge clk);
    jump_taken = 1'b0;
    resp_hold  = 1'b0;
    for (int i = 0; i < 3; i++) expect_pc(32'h6000 + 32'(4 * i), 1'b0);
    drain("t5b");

    // 6: asynchronous reset mid-stream
    redirect(1'b0, 1'b1, 32'h0000_7000, 1);
    repeat (3) @(negedge clk);
    #2;
    check("t6_pre_valid", W'(out_valid), 32'd1);
    rst = 1'b0;
    #1;
    check("t6_valid_cleared", W'(out_valid), 32'd0);
    check("t6_req_cleared", W'(fetch_req), 32'd0);
    check("t6_addr_reset", fetch_req_addr, 32'h0000_1000);
    check("t6_pc_out_cleared", pc_out, 32'd0);
    check("t6_halted_cleared", W'(halted), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) expect_pc(32'h1000 + 32'(4 * i), 1'b0);
    drain("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
